// File: rtl/pllmap_status_tx.sv
// SPI-slave readback transmitter: shifts a shadowed PLL status word out on miso, LSB first, SPI mode 0.
// sclk/ss_n are oversampled in clk; miso moves SYNC_STAGES+2 clk after the sclk fall / ss_n fall pin edge.
module pllmap_status_tx #(
  parameter int DATA_WIDTH  = 512,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic [DATA_WIDTH-1:0] status_i,
  input  logic                  load,
  output logic                  miso,
  output logic                  busy,
  output logic                  done,
  output logic                  abort
);
  localparam int PW = SYNC_STAGES + 1;
  localparam int FW = $clog2(PW + 1);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN} state_e;

  logic [PW-1:0]         sclk_pipe_q, sclk_pipe_d;
  logic [PW-1:0]         ss_pipe_q, ss_pipe_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic                  pipe_ok;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_end_q, frame_end_d;
  logic                  sclk_rise_q, sclk_rise_d;
  logic                  sclk_fall_q, sclk_fall_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_nxt, start_word;
  logic [CW-1:0]         rise_cnt_q, rise_cnt_d, rise_cnt_nxt;
  state_e                state_q, state_d;
  logic                  miso_q, miso_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;

  // Top pipe bit is the history flop; the one below it is the synchronized pin.
  // Edges are only trusted once every stage holds a real pin sample, so a low
  // ss_n at reset release is not mistaken for a frame start.
  always_comb begin
    sclk_pipe_d   = {sclk_pipe_q[PW-2:0], sclk};
    ss_pipe_d     = {ss_pipe_q[PW-2:0], ss_n};
    pipe_ok       = (fill_q == FW'(PW));
    fill_d        = pipe_ok ? fill_q : fill_q + FW'(1);
    frame_start_d = pipe_ok &  ss_pipe_q[PW-1]   & ~ss_pipe_q[PW-2];
    frame_end_d   = pipe_ok & ~ss_pipe_q[PW-1]   &  ss_pipe_q[PW-2];
    sclk_rise_d   = pipe_ok & ~sclk_pipe_q[PW-1] &  sclk_pipe_q[PW-2];
    sclk_fall_d   = pipe_ok &  sclk_pipe_q[PW-1] & ~sclk_pipe_q[PW-2];
    shadow_d      = load ? status_i : shadow_q;
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    rise_cnt_d   = rise_cnt_q;
    miso_d       = miso_q;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    shift_nxt    = shift_q >> 1;
    start_word   = load ? status_i : shadow_q;
    rise_cnt_nxt = rise_cnt_q + CW'(sclk_rise_q);
    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (frame_start_q) begin
          shift_d    = start_word;
          miso_d     = start_word[0];
          rise_cnt_d = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        rise_cnt_d = rise_cnt_nxt;
        if (sclk_fall_q) begin
          shift_d = shift_nxt;
          miso_d  = shift_nxt[0];
        end
        // A rise landing with the ss_n rise is counted before the frame end is judged.
        if (rise_cnt_nxt == CW'(DATA_WIDTH)) begin
          done_d  = 1'b1;
          miso_d  = 1'b0;
          state_d = frame_end_q ? S_IDLE : S_DRAIN;
        end else if (frame_end_q) begin
          abort_d = 1'b1;
          miso_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        miso_d = 1'b0;
        if (frame_end_q) state_d = S_IDLE;
      end
      default: begin
        miso_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_pipe_q   <= '0;
      ss_pipe_q     <= '1;
      fill_q        <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      sclk_rise_q   <= 1'b0;
      sclk_fall_q   <= 1'b0;
      shadow_q      <= '0;
      shift_q       <= '0;
      rise_cnt_q    <= '0;
      state_q       <= S_IDLE;
      miso_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      sclk_pipe_q   <= sclk_pipe_d;
      ss_pipe_q     <= ss_pipe_d;
      fill_q        <= fill_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      sclk_rise_q   <= sclk_rise_d;
      sclk_fall_q   <= sclk_fall_d;
      shadow_q      <= shadow_d;
      shift_q       <= shift_d;
      rise_cnt_q    <= rise_cnt_d;
      state_q       <= state_d;
      miso_q        <= miso_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
    end
  end

  assign miso  = miso_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign abort = abort_q;

endmodule

// File: tb/tb_pllmap_status_tx.sv
// Bench for pllmap_status_tx: an SPI mode-0 master model captures miso on each sclk rise and the
// captured frame, pulse counts and pulse latencies are checked against a shadow-word model.
module tb_pllmap_status_tx;
  localparam int DW   = 32;
  localparam int CAPW = DW + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          ss_n = 1'b1;
  logic [DW-1:0] status_i = '0;
  logic          load = 1'b0;
  logic          miso, busy, done, abort;

  int            checks = 0;
  int            failures = 0;
  int            done_cnt = 0;
  int            abort_cnt = 0;
  time           last_done_t = 0;
  time           last_abort_t = 0;
  bit            mon_en = 1'b0;
  logic          prev_done = 1'b0;
  logic [DW-1:0] model_shadow = '0;
  logic [CAPW-1:0] cap;

  pllmap_status_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .status_i(status_i),
    .load(load), .miso(miso), .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [DW-1:0] v);
    status_i = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    model_shadow = v;
  endtask

  // Per-cycle rules that hold regardless of frame content.
  always @(posedge clk) begin
    time t;
    t = $time;
    #1;
    if (mon_en) begin
      if (!busy) chk("idle_miso", miso, 1'b0);
      chk("done_abort_excl", done & abort, 1'b0);
      chk("done_one_cycle", done & prev_done, 1'b0);
      if (done) begin done_cnt++; last_done_t = t; end
      if (abort) begin abort_cnt++; last_abort_t = t; end
      prev_done = done;
    end
  end

  task automatic run_frame(input int rises, input int rst_at, input bit mid_load,
                           input logic [DW-1:0] mid_val, input bit sim_load,
                           input logic [DW-1:0] sim_val, output logic [CAPW-1:0] cp);
    logic [DW-1:0]   word;
    logic [CAPW-1:0] exp_cap;
    int              d0, a0, waited;
    bit              exp_done, exp_abort;
    time             done_rise_t, end_t;
    word        = sim_load ? sim_val : model_shadow;
    d0          = done_cnt;
    a0          = abort_cnt;
    cp          = '0;
    exp_cap     = '0;
    done_rise_t = 0;
    exp_done    = (rst_at < 0) && (rises >= DW);
    exp_abort   = (rst_at < 0) && (rises < DW);
    for (int i = 0; i < rises; i++)
      if (!(rst_at >= 0 && i >= rst_at) && i < DW) exp_cap[i] = word[i];

    ss_n = 1'b0;
    if (sim_load) begin
      // Load lands in the very cycle the synchronized ss_n fall is acted on.
      tick(3);
      status_i = sim_val;
      load = 1'b1;
      tick(1);
      load = 1'b0;
      model_shadow = sim_val;
      tick(6);
    end else begin
      tick(10);
    end
    for (int i = 0; i < rises; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_shadow = '0;
        tick(1);
      end
      if (mid_load && i == rises / 2) do_load(mid_val);
      cp[i] = miso;
      sclk = 1'b1;
      if (i == DW - 1) done_rise_t = $time;
      tick(5);
      sclk = 1'b0;
      tick(5);
    end
    chk("busy_before_end", busy, (rst_at < 0));
    ss_n = 1'b1;
    end_t = $time;
    waited = 0;
    while (busy && waited < 8) begin
      tick(1);
      waited++;
    end
    chk("busy_fall", busy, 1'b0);
    tick(4);
    chk("frame_data", cp, exp_cap);
    chk("done_count", done_cnt - d0, exp_done);
    chk("abort_count", abort_cnt - a0, exp_abort);
    if (exp_done && done_cnt > d0) chk("done_latency", last_done_t - done_rise_t, 35);
    if (exp_abort && abort_cnt > a0) chk("abort_latency", last_abort_t - end_t, 35);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(5);
    chk("rst_miso", miso, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_abort", abort, 1'b0);
    mon_en = 1'b1;

    do_load(32'h31);
    run_frame(DW, -1, 1'b0, '0, 1'b0, '0, cap);
    chk("lit_full_0x31", cap[DW-1:0], 32'h31);

    do_load(32'h1F);
    run_frame(DW, -1, 1'b1, 32'h0A, 1'b0, '0, cap);
    chk("lit_midload_cur", cap[DW-1:0], 32'h1F);
    run_frame(DW, -1, 1'b0, '0, 1'b0, '0, cap);
    chk("lit_midload_next", cap[DW-1:0], 32'h0A);

    run_frame(DW, -1, 1'b0, '0, 1'b1, 32'h55, cap);
    chk("lit_sim_load", cap[DW-1:0], 32'h55);

    run_frame(7, -1, 1'b0, '0, 1'b0, '0, cap);
    chk("lit_abort_bits", cap[6:0], 7'h55);
    run_frame(DW, -1, 1'b0, '0, 1'b0, '0, cap);
    chk("lit_after_abort", cap[DW-1:0], 32'h55);

    do_load(32'hABCD1234);
    run_frame(20, 10, 1'b0, '0, 1'b0, '0, cap);
    chk("lit_rst_bits", cap[19:0], 20'h00234);
    run_frame(DW, -1, 1'b0, '0, 1'b0, '0, cap);
    chk("lit_after_rst", cap[DW-1:0], 32'h0);

    do_load(32'hF0F0A5A5);
    run_frame(DW + 4, -1, 1'b0, '0, 1'b0, '0, cap);
    chk("lit_over_word", cap[DW-1:0], 32'hF0F0A5A5);
    chk("lit_over_extra", cap[DW+3:DW], 4'h0);

    for (int k = 0; k < 12; k++) begin
      int            rises;
      bit            mid, sim;
      logic [DW-1:0] v1, v2;
      v1 = $urandom;
      v2 = $urandom;
      if ($urandom_range(0, 1) == 1) do_load($urandom);
      rises = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : DW + $urandom_range(0, 4);
      mid   = ($urandom_range(0, 1) == 1);
      sim   = ($urandom_range(0, 3) == 0);
      run_frame(rises, -1, mid, v1, sim, v2, cap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
